uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter for the processor's serial console path. It replaces the single-byte, ready-polled transmitter with a FIFO-fronted serialiser, so the core can issue bursts of writes without stalling on every character. Character width, parity, stop-bit count, baud divisor and buffer depth are set by parameters. It sits between the core's output-byte port and the `txd` pin.

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: circular FIFO in front of a start/data/parity/stop
// serialiser driving a registered txd line.
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned DEPTH_LOG   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [DEPTH_LOG:0]   count,
  output logic                 busy,
  output logic                 overflow,
  output logic                 txd
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG;
  localparam int unsigned CNT_W  = DEPTH_LOG + 1;
  localparam int unsigned BCNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned BIDX_W = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DEPTH_LOG-1:0] wptr;
  logic [DEPTH_LOG-1:0] rptr;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [BCNT_W-1:0]    bcnt;
  logic [BIDX_W-1:0]    bidx;
  logic                 bit_end;
  logic                 last_stop;
  logic                 push;
  logic                 pop;

  // wready depends only on the registered count, so a same-cycle pop never frees a slot
  assign wready    = (count != CNT_W'(DEPTH));
  assign push      = wvalid && wready;
  assign bit_end   = (bcnt == BCNT_W'(CLK_PER_BIT - 1));
  assign last_stop = (state == STOP) && bit_end && (bidx == BIDX_W'(STOP_BITS - 1));
  assign pop       = (count != '0) && ((state == IDLE) || last_stop);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (wvalid && !wready) overflow <= 1'b1;
    end
  end

  // Serialiser; a pop on the last stop edge starts the next frame with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bcnt    <= '0;
      bidx    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (pop) begin
        state   <= START;
        bcnt    <= '0;
        bidx    <= '0;
        txd     <= 1'b0;
        shreg   <= mem[rptr];
        par_bit <= (PARITY == 1) ? ~(^mem[rptr]) : (^mem[rptr]);
      end else begin
        case (state)
          IDLE: begin
            txd <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state <= DATA;
              bcnt  <= '0;
              bidx  <= '0;
              txd   <= shreg[0];
              shreg <= shreg >> 1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              bcnt <= '0;
              if (bidx == BIDX_W'(DATA_BITS - 1)) begin
                bidx <= '0;
                if (PARITY != 0) begin
                  state <= PAR;
                  txd   <= par_bit;
                end else begin
                  state <= STOP;
                  txd   <= 1'b1;
                end
              end else begin
                bidx  <= bidx + 1'b1;
                txd   <= shreg[0];
                shreg <= shreg >> 1;
              end
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          PAR: begin
            if (bit_end) begin
              state <= STOP;
              bcnt  <= '0;
              bidx  <= '0;
              txd   <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          STOP: begin
            txd <= 1'b1;
            if (bit_end) begin
              bcnt <= '0;
              if (last_stop) state <= IDLE;
              else           bidx  <= bidx + 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations checked cycle by cycle against a
// frame-schedule model (each accepted character owns a start edge and a frame length).
module tb_uart_tx_fifo;

  localparam int NDUT = 3;
  localparam int CPB   [NDUT] = '{4, 4, 3};
  localparam int DBITS [NDUT] = '{8, 7, 8};
  localparam int PARM  [NDUT] = '{0, 1, 2};
  localparam int SBITS [NDUT] = '{1, 2, 1};
  localparam int DEPTH [NDUT] = '{4, 4, 8};

  logic       clk = 1'b0;
  logic       rst    [NDUT];
  logic       wvalid [NDUT];
  logic [7:0] wdata  [NDUT];
  logic       txd    [NDUT];
  logic       busy   [NDUT];
  logic       wready [NDUT];
  logic       ovf    [NDUT];
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [3:0] cnt2;

  int cyc;
  int total;
  int bad;

  typedef struct {
    int k;
    int s;
    int ch;
  } frame_t;

  frame_t frames[$];
  int     last_end [NDUT];
  bit     m_ovf    [NDUT];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH_LOG(2)) u0 (
    .clk(clk), .rst(rst[0]), .wdata(wdata[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .count(cnt0), .busy(busy[0]), .overflow(ovf[0]), .txd(txd[0]));

  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DEPTH_LOG(2)) u1 (
    .clk(clk), .rst(rst[1]), .wdata(wdata[1][6:0]), .wvalid(wvalid[1]), .wready(wready[1]),
    .count(cnt1), .busy(busy[1]), .overflow(ovf[1]), .txd(txd[1]));

  uart_tx_fifo #(.CLK_PER_BIT(3), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH_LOG(3)) u2 (
    .clk(clk), .rst(rst[2]), .wdata(wdata[2]), .wvalid(wvalid[2]), .wready(wready[2]),
    .count(cnt2), .busy(busy[2]), .overflow(ovf[2]), .txd(txd[2]));

  function automatic int obs_cnt(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int flen(int k);
    return (1 + DBITS[k] + ((PARM[k] != 0) ? 1 : 0) + SBITS[k]) * CPB[k];
  endfunction

  // characters accepted but whose frame has not yet started after edge e
  function automatic int m_count(int k, int e);
    int n = 0;
    foreach (frames[i]) if (frames[i].k == k && frames[i].s > e) n++;
    return n;
  endfunction

  function automatic bit m_busy(int k, int e);
    foreach (frames[i])
      if (frames[i].k == k && frames[i].s <= e && e < frames[i].s + flen(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_txd(int k, int e);
    int b;
    int ch;
    bit p;
    foreach (frames[i]) begin
      if (frames[i].k == k && frames[i].s <= e && e < frames[i].s + flen(k)) begin
        b  = (e - frames[i].s) / CPB[k];
        ch = frames[i].ch;
        if (b == 0) return 1'b0;
        if (b <= DBITS[k]) return ch[b-1];
        if (PARM[k] != 0 && b == DBITS[k] + 1) begin
          p = 1'b0;
          for (int j = 0; j < DBITS[k]; j++) p = p ^ ch[j];
          return (PARM[k] == 1) ? ~p : p;
        end
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  // Advance one clock, updating the model with the inputs seen at this edge
  task automatic step();
    int     e;
    int     s;
    frame_t f;
    frame_t keep[$];
    e = cyc + 1;
    for (int k = 0; k < NDUT; k++) begin
      if (rst[k]) begin
        keep.delete();
        foreach (frames[i]) if (frames[i].k != k) keep.push_back(frames[i]);
        frames      = keep;
        last_end[k] = 0;
        m_ovf[k]    = 1'b0;
      end else if (wvalid[k]) begin
        if (m_count(k, e - 1) < DEPTH[k]) begin
          s    = (e + 1 > last_end[k]) ? e + 1 : last_end[k];
          f.k  = k;
          f.s  = s;
          f.ch = int'(wdata[k]) & ((1 << DBITS[k]) - 1);
          frames.push_back(f);
          last_end[k] = s + flen(k);
        end else begin
          m_ovf[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = e;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (txd[k] !== 1'b1)   begin bad++; $display("FAIL reset_txd dut=%0d got=%b exp=1", k, txd[k]); end
      total++; if (busy[k] !== 1'b0)  begin bad++; $display("FAIL reset_busy dut=%0d got=%b exp=0", k, busy[k]); end
      total++; if (obs_cnt(k) != 0)   begin bad++; $display("FAIL reset_count dut=%0d got=%0d exp=0", k, obs_cnt(k)); end
      total++; if (wready[k] !== 1'b1) begin bad++; $display("FAIL reset_wready dut=%0d got=%b exp=1", k, wready[k]); end
      total++; if (ovf[k] !== 1'b0)   begin bad++; $display("FAIL reset_overflow dut=%0d got=%b exp=0", k, ovf[k]); end
    end
  endtask

  task automatic test_single_frame();
    int busy_cyc = 0;
    wdata[0] = 8'h55; wvalid[0] = 1'b1; step(); wvalid[0] = 1'b0;
    total++; if (obs_cnt(0) != 1) begin bad++; $display("FAIL single_count_after_write got=%0d exp=1", obs_cnt(0)); end
    total++; if (txd[0] !== 1'b1) begin bad++; $display("FAIL single_txd_after_write got=%b exp=1", txd[0]); end
    for (int i = 0; i < 48; i++) begin
      step();
      if (busy[0] === 1'b1) busy_cyc++;
      total++; if (txd[0] !== m_txd(0, cyc)) begin bad++; $display("FAIL single_txd cyc=%0d got=%b exp=%b", cyc, txd[0], m_txd(0, cyc)); end
      total++; if (busy[0] !== m_busy(0, cyc)) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy[0], m_busy(0, cyc)); end
      total++; if (obs_cnt(0) != m_count(0, cyc)) begin bad++; $display("FAIL single_count cyc=%0d got=%0d exp=%0d", cyc, obs_cnt(0), m_count(0, cyc)); end
    end
    total++; if (busy_cyc != 40) begin bad++; $display("FAIL single_busy_len got=%0d exp=40", busy_cyc); end
  endtask

  task automatic test_parity();
    int busy_cyc = 0;
    int w;
    wdata[1] = 8'h03; wvalid[1] = 1'b1; step(); wvalid[1] = 1'b0; w = cyc;
    for (int i = 0; i < 50; i++) begin
      step();
      if (busy[1] === 1'b1) busy_cyc++;
      total++; if (txd[1] !== m_txd(1, cyc)) begin bad++; $display("FAIL parity_txd cyc=%0d got=%b exp=%b", cyc, txd[1], m_txd(1, cyc)); end
      total++; if (busy[1] !== m_busy(1, cyc)) begin bad++; $display("FAIL parity_busy cyc=%0d got=%b exp=%b", cyc, busy[1], m_busy(1, cyc)); end
      if (cyc == w + 1 + 33) begin
        total++; if (txd[1] !== 1'b1) begin bad++; $display("FAIL parity_bit got=%b exp=1", txd[1]); end
      end
    end
    total++; if (busy_cyc != 44) begin bad++; $display("FAIL parity_frame_len got=%0d exp=44", busy_cyc); end
  endtask

  task automatic test_back_to_back();
    int busy_cyc = 0;
    int peak = 0;
    for (int i = 0; i < 128; i++) begin
      wvalid[0] = (i < 3);
      wdata[0]  = 8'(8'h41 + i);
      step();
      if (busy[0] === 1'b1) busy_cyc++;
      if (obs_cnt(0) > peak) peak = obs_cnt(0);
      total++; if (txd[0] !== m_txd(0, cyc)) begin bad++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", cyc, txd[0], m_txd(0, cyc)); end
      total++; if (obs_cnt(0) != m_count(0, cyc)) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", cyc, obs_cnt(0), m_count(0, cyc)); end
    end
    wvalid[0] = 1'b0;
    total++; if (peak != 2) begin bad++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
    total++; if (busy_cyc != 120) begin bad++; $display("FAIL b2b_busy_len got=%0d exp=120", busy_cyc); end
    total++; if (obs_cnt(0) != 0) begin bad++; $display("FAIL b2b_final_count got=%0d exp=0", obs_cnt(0)); end
  endtask

  task automatic test_overflow();
    int busy_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      wvalid[0] = 1'b1; wdata[0] = 8'($urandom);
      step();
      if (busy[0] === 1'b1) busy_cyc++;
      if (i == 4) begin
        total++; if (wready[0] !== 1'b0) begin bad++; $display("FAIL ovf_wready_full got=%b exp=0", wready[0]); end
        total++; if (obs_cnt(0) != 4) begin bad++; $display("FAIL ovf_count_full got=%0d exp=4", obs_cnt(0)); end
        total++; if (ovf[0] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf[0]); end
      end
    end
    wvalid[0] = 1'b0;
    total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf[0]); end
    for (int i = 0; i < 205; i++) begin
      step();
      if (busy[0] === 1'b1) busy_cyc++;
      total++; if (txd[0] !== m_txd(0, cyc)) begin bad++; $display("FAIL ovf_txd cyc=%0d got=%b exp=%b", cyc, txd[0], m_txd(0, cyc)); end
      total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_sticky cyc=%0d got=%b exp=1", cyc, ovf[0]); end
    end
    total++; if (busy_cyc != 200) begin bad++; $display("FAIL ovf_busy_len got=%0d exp=200 (5 frames)", busy_cyc); end
  endtask

  task automatic test_write_with_pop();
    int w;
    wvalid[0] = 1'b1; wdata[0] = 8'hA5; step(); w = cyc;
    wdata[0] = 8'h3C; step(); wvalid[0] = 1'b0;
    while (cyc < w + 40) begin
      step();
      total++; if (txd[0] !== m_txd(0, cyc)) begin bad++; $display("FAIL wp_txd cyc=%0d got=%b exp=%b", cyc, txd[0], m_txd(0, cyc)); end
    end
    wvalid[0] = 1'b1; wdata[0] = 8'hC3; step(); wvalid[0] = 1'b0;
    total++; if (obs_cnt(0) != 1) begin bad++; $display("FAIL wp_count got=%0d exp=1", obs_cnt(0)); end
    for (int i = 0; i < 90; i++) begin
      step();
      total++; if (txd[0] !== m_txd(0, cyc)) begin bad++; $display("FAIL wp_txd2 cyc=%0d got=%b exp=%b", cyc, txd[0], m_txd(0, cyc)); end
      total++; if (obs_cnt(0) != m_count(0, cyc)) begin bad++; $display("FAIL wp_count2 cyc=%0d got=%0d exp=%0d", cyc, obs_cnt(0), m_count(0, cyc)); end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    for (int i = 0; i < 3; i++) begin
      wvalid[0] = 1'b1; wdata[0] = 8'(8'h61 + i); step();
      if (i == 0) w = cyc;
    end
    wvalid[0] = 1'b0;
    while (cyc < w + 17) begin
      step();
      total++; if (txd[0] !== m_txd(0, cyc)) begin bad++; $display("FAIL rm_txd cyc=%0d got=%b exp=%b", cyc, txd[0], m_txd(0, cyc)); end
    end
    total++; if (obs_cnt(0) != 2) begin bad++; $display("FAIL rm_queued got=%0d exp=2", obs_cnt(0)); end
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    total++; if (txd[0] !== 1'b1) begin bad++; $display("FAIL rm_txd_after got=%b exp=1", txd[0]); end
    total++; if (obs_cnt(0) != 0) begin bad++; $display("FAIL rm_count_after got=%0d exp=0", obs_cnt(0)); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rm_busy_after got=%b exp=0", busy[0]); end
    total++; if (ovf[0] !== 1'b0) begin bad++; $display("FAIL rm_ovf_after got=%b exp=0", ovf[0]); end
    for (int i = 0; i < 100; i++) begin
      step();
      total++; if (txd[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL rm_quiet cyc=%0d txd=%b busy=%b exp txd=1 busy=0", cyc, txd[0], busy[0]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      wvalid[2] = ($urandom_range(0, 3) == 0);
      wdata[2]  = 8'($urandom);
      rst[2]    = ($urandom_range(0, 399) == 0);
      step();
      total++; if (txd[2] !== m_txd(2, cyc)) begin bad++; $display("FAIL rnd_txd cyc=%0d got=%b exp=%b", cyc, txd[2], m_txd(2, cyc)); end
      total++; if (busy[2] !== m_busy(2, cyc)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy[2], m_busy(2, cyc)); end
      total++; if (obs_cnt(2) != m_count(2, cyc)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, obs_cnt(2), m_count(2, cyc)); end
      total++; if (wready[2] !== (m_count(2, cyc) < DEPTH[2])) begin bad++; $display("FAIL rnd_wready cyc=%0d got=%b exp=%b", cyc, wready[2], m_count(2, cyc) < DEPTH[2]); end
      total++; if (ovf[2] !== m_ovf[2]) begin bad++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", cyc, ovf[2], m_ovf[2]); end
    end
    wvalid[2] = 1'b0;
    rst[2]    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; wvalid[k] = 1'b0; wdata[k] = 8'h00;
      last_end[k] = 0; m_ovf[k] = 1'b0;
    end
    step();
    step();
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_write_with_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
